// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - single-stage instruction decode and issue with register scoreboard
module decode_issue #(
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    output logic [AWIDTH-1:0] addr_rs,
    output logic [AWIDTH-1:0] addr_rt,
    output logic              req_rs,
    output logic              req_rt,
    input  logic              wb_valid,
    input  logic [AWIDTH-1:0] wb_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [AWIDTH-1:0] out_rd,
    output logic [15:0]       out_imm,
    output logic              out_wr_en,
    input  logic              flush,
    output logic              illegal,
    output logic [15:0]       stall_cnt
);

    localparam int NREG = 1 << AWIDTH;

    logic [3:0] op, f2, f1, f0;
    assign op = instr[15:12];
    assign f2 = instr[11:8];
    assign f1 = instr[7:4];
    assign f0 = instr[3:0];

    logic [3:0]        dec_op;
    logic [AWIDTH-1:0] dec_rd, dec_rs, dec_rt;
    logic              use_rs, use_rt, dec_wr, dec_ill;
    logic [15:0]       dec_imm;

    always_comb begin
        dec_op  = op;
        dec_rd  = '0;
        dec_rs  = AWIDTH'(f1);
        dec_rt  = AWIDTH'(f0);
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        dec_wr  = 1'b0;
        dec_imm = '0;
        dec_ill = 1'b0;
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4: begin
                dec_rd = AWIDTH'(f2);
                use_rs = 1'b1;
                use_rt = 1'b1;
                dec_wr = 1'b1;
            end
            4'h5, 4'h6: begin
                dec_rd  = AWIDTH'(f2);
                use_rs  = 1'b1;
                dec_wr  = 1'b1;
                dec_imm = {{12{f0[3]}}, f0};
            end
            4'h7: begin
                // store: f1 is the base, f2 the data register
                dec_rt  = AWIDTH'(f2);
                use_rs  = 1'b1;
                use_rt  = 1'b1;
                dec_imm = {{12{f0[3]}}, f0};
            end
            4'h8: begin
                dec_rs  = AWIDTH'(f2);
                dec_rt  = AWIDTH'(f1);
                use_rs  = 1'b1;
                use_rt  = 1'b1;
                dec_imm = {{12{f0[3]}}, f0};
            end
            4'h0: ;
            default: begin
                dec_op  = 4'h0;
                dec_ill = 1'b1;
            end
        endcase
    end

    logic [NREG-1:0] pend_q, pend_d, release_mask, pend_eff;
    logic            out_valid_q, out_valid_d, out_wr_en_q, out_wr_en_d, illegal_q, illegal_d;
    logic [3:0]        out_op_q, out_op_d;
    logic [AWIDTH-1:0] out_rd_q, out_rd_d;
    logic [15:0]       out_imm_q, out_imm_d, stall_q, stall_d;
    logic              hazard, issue;

    // writeback releases before the hazard check, so a same-cycle write never stalls
    assign release_mask = wb_valid ? (NREG'(1) << wb_addr) : '0;
    assign pend_eff     = pend_q & ~release_mask;
    assign hazard       = (use_rs && pend_eff[dec_rs]) || (use_rt && pend_eff[dec_rt]) ||
                          (dec_wr && pend_eff[dec_rd]);

    assign in_ready = clear_n && !flush && !hazard && (!out_valid_q || out_ready);
    assign issue    = in_valid && in_ready;
    assign addr_rs  = dec_rs;
    assign addr_rt  = dec_rt;
    assign req_rs   = issue && use_rs;
    assign req_rt   = issue && use_rt;

    always_comb begin
        pend_d      = pend_eff;
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_rd_d    = out_rd_q;
        out_imm_d   = out_imm_q;
        out_wr_en_d = out_wr_en_q;
        illegal_d   = issue && dec_ill;
        stall_d     = stall_q;
        if (flush && out_valid_q && out_wr_en_q) begin
            pend_d[out_rd_q] = 1'b0;
        end
        // applied last so a new destination stays pending over a same-cycle release
        if (issue && dec_wr) begin
            pend_d[dec_rd] = 1'b1;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (issue) begin
            out_valid_d = 1'b1;
            out_op_d    = dec_op;
            out_rd_d    = dec_rd;
            out_imm_d   = dec_imm;
            out_wr_en_d = dec_wr;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (in_valid && hazard && !flush && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_rd_q    <= '0;
            out_imm_q   <= '0;
            out_wr_en_q <= 1'b0;
            illegal_q   <= 1'b0;
            stall_q     <= '0;
        end else begin
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_rd_q    <= out_rd_d;
            out_imm_q   <= out_imm_d;
            out_wr_en_q <= out_wr_en_d;
            illegal_q   <= illegal_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_rd    = out_rd_q;
    assign out_imm   = out_imm_q;
    assign out_wr_en = out_wr_en_q;
    assign illegal   = illegal_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - scoreboard bench for decode_issue against a behavioural model
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] instr = '0;
    logic [3:0]  addr_rs, addr_rt;
    logic        req_rs, req_rt;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_op;
    logic [3:0]  out_rd;
    logic [15:0] out_imm;
    logic        out_wr_en;
    logic        flush = 1'b0;
    logic        illegal;
    logic [15:0] stall_cnt;

    decode_issue #(.AWIDTH(4)) dut (
        .clk(clk), .clear_n(clear_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .addr_rs(addr_rs), .addr_rt(addr_rt), .req_rs(req_rs), .req_rt(req_rt),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_imm(out_imm), .out_wr_en(out_wr_en),
        .flush(flush), .illegal(illegal), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        bit          use_rs;
        bit          use_rt;
        bit          wr;
        bit          ill;
        logic [15:0] imm;
    } dec_t;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [15:0] imm;
        bit          wr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    bit [15:0]   pend = '0;
    bit          m_ov = 0;
    bit          m_ill = 0;
    int          m_stall = 0;
    dec_t        m_held;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic [15:0] sext4(logic [3:0] v);
        int s;
        s = (v >= 8) ? int'(v) - 16 : int'(v);
        return 16'(s);
    endfunction

    function automatic dec_t model_dec(logic [15:0] ins);
        dec_t d;
        logic [3:0] o, a, b, c;
        o = ins[15:12]; a = ins[11:8]; b = ins[7:4]; c = ins[3:0];
        d = '{op: 4'h0, rd: 4'h0, rs: 4'h0, rt: 4'h0, use_rs: 0, use_rt: 0, wr: 0, ill: 0, imm: 16'h0};
        if (o >= 1 && o <= 4) begin
            d.op = o; d.rd = a; d.rs = b; d.rt = c; d.use_rs = 1; d.use_rt = 1; d.wr = 1;
        end else if (o == 5 || o == 6) begin
            d.op = o; d.rd = a; d.rs = b; d.use_rs = 1; d.wr = 1; d.imm = sext4(c);
        end else if (o == 7) begin
            d.op = o; d.rs = b; d.rt = a; d.use_rs = 1; d.use_rt = 1; d.imm = sext4(c);
        end else if (o == 8) begin
            d.op = o; d.rs = a; d.rt = b; d.use_rs = 1; d.use_rt = 1; d.imm = sext4(c);
        end else if (o >= 9) begin
            d.ill = 1;
        end
        return d;
    endfunction

    task automatic step(bit v, logic [15:0] ins, bit wbv, logic [3:0] wba, bit ordy, bit fl);
        dec_t      d;
        bit [15:0] eff;
        bit        haz, rdy, iss;
        in_valid = v; instr = ins; wb_valid = wbv; wb_addr = wba; out_ready = ordy; flush = fl;
        @(negedge clk);
        d   = model_dec(ins);
        eff = pend;
        if (wbv) eff[wba] = 1'b0;
        haz = (d.use_rs && eff[d.rs]) || (d.use_rt && eff[d.rt]) || (d.wr && eff[d.rd]);
        rdy = !fl && !haz && (!m_ov || ordy);
        iss = v && rdy;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("req_rs", 32'(req_rs), 32'(iss && d.use_rs));
        chk("req_rt", 32'(req_rt), 32'(iss && d.use_rt));
        if (iss && d.use_rs) chk("addr_rs", 32'(addr_rs), 32'(d.rs));
        if (iss && d.use_rt) chk("addr_rt", 32'(addr_rt), 32'(d.rt));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        pend = eff;
        if (fl && m_ov && m_held.wr) pend[m_held.rd] = 1'b0;
        if (iss && d.wr) pend[d.rd] = 1'b1;
        if (v && haz && !fl && m_stall < 65535) m_stall++;
        m_ill = iss && d.ill;
        if (iss) begin
            exp_q.push_back('{op: d.op, rd: d.rd, imm: d.imm, wr: d.wr});
            m_ov   = 1;
            m_held = d;
        end else if (fl || ordy) begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_n = 1'b0; in_valid = 1'b1; instr = 16'h2431;
        wb_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_req_rs", 32'(req_rs), 0);
        chk("rst_req_rt", 32'(req_rt), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_op", 32'(out_op), 0);
        chk("rst_out_rd", 32'(out_rd), 0);
        chk("rst_out_imm", 32'(out_imm), 0);
        chk("rst_out_wr_en", 32'(out_wr_en), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        pend = '0; m_ov = 0; m_ill = 0; m_stall = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        clear_n = 1'b1;
    endtask

    task automatic drain();
        for (int r = 0; r < 16; r++) step(0, 16'h0, 1, 4'(r), 1, 0);
    endtask

    // monitor: compares the presented payload with the oldest expected issue
    always @(negedge clk) begin
        if (clear_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("out_spurious", 32'(out_valid), 0);
            end else begin
                chk("out_op", 32'(out_op), 32'(exp_q[0].op));
                chk("out_rd", 32'(out_rd), 32'(exp_q[0].rd));
                chk("out_imm", 32'(out_imm), 32'(exp_q[0].imm));
                chk("out_wr_en", 32'(out_wr_en), 32'(exp_q[0].wr));
                if (out_ready || flush) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int pl[$];
        bit wbv;
        logic [3:0] wba;
        do_reset();

        step(1, 16'h1312, 0, 0, 1, 0);
        step(1, 16'h2431, 0, 0, 1, 0);
        step(1, 16'h2431, 0, 0, 1, 0);
        step(1, 16'h2431, 1, 3, 1, 0);
        step(1, 16'h551F, 0, 0, 1, 0);
        step(1, 16'h1611, 0, 0, 0, 0);
        step(1, 16'h1611, 0, 0, 0, 0);
        step(1, 16'h1611, 0, 0, 1, 0);
        step(1, 16'h6610, 1, 6, 1, 0);
        step(0, 16'h0000, 0, 0, 0, 0);
        step(0, 16'h0000, 0, 0, 0, 1);
        step(1, 16'h1161, 0, 0, 1, 0);
        step(1, 16'hA123, 0, 0, 1, 0);
        step(0, 16'h0000, 0, 0, 0, 0);
        step(0, 16'h0000, 0, 0, 1, 0);
        drain();
        step(1, 16'h1200, 1, 2, 1, 0);
        step(1, 16'h3520, 0, 0, 1, 0);
        step(1, 16'h3520, 0, 0, 1, 0);
        step(1, 16'h3520, 1, 2, 1, 0);
        step(1, 16'h0000, 0, 0, 1, 0);
        drain();

        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ins;
            pl.delete();
            for (int r = 0; r < 16; r++) if (pend[r]) pl.push_back(r);
            wbv = 0; wba = 4'(($urandom % 16));
            if (pl.size() > 0 && ($urandom % 2) == 0) begin
                wbv = 1;
                wba = 4'(pl[$urandom % pl.size()]);
            end else if (($urandom % 8) == 0) begin
                wbv = 1;
            end
            ins = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            step(($urandom % 4) != 0, ins, wbv, wba, ($urandom % 10) < 7, ($urandom % 20) == 0);
        end
        drain();

        step(1, 16'h1312, 0, 0, 1, 0);
        for (int n = 0; n < 65540; n++) step(1, 16'h2431, 0, 0, 1, 0);
        do_reset();
        step(1, 16'h2431, 0, 0, 1, 0);
        step(1, 16'h1312, 0, 0, 1, 0);
        step(0, 16'h0000, 0, 0, 1, 0);
        step(0, 16'h0000, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have parameter AWIDTH, default 4, register address width; only 4 is supported because the instruction fields are fixed at 4 bits.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-003 SHALL have port clear_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1) and instr (input, 16), the upstream instruction handshake.
REQ-005 SHALL have ports addr_rs and addr_rt (output, AWIDTH) plus req_rs and req_rt (output, 1), the register-file read request.
REQ-006 SHALL have ports wb_valid (input, 1) and wb_addr (input, AWIDTH), the register-file write observed for scoreboard release.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the downstream handshake.
REQ-008 SHALL have ports out_op (output, 4), out_rd (output, AWIDTH), out_imm (output, 16) and out_wr_en (output, 1), the decoded payload.
REQ-009 SHALL have ports flush (input, 1) and illegal (output, 1), plus stall_cnt (output, 16), a saturating hazard-stall count.

Function
REQ-010 SHALL decode the 16-bit instruction as opcode[15:12], f2[11:8], f1[7:4], f0[3:0].
REQ-011 SHALL decode opcodes 0x1-0x4 (ADD/SUB/AND/OR) as: rd=f2, rs=f1, rt=f0, both reads, write, imm=0.
REQ-012 SHALL decode ADDI (0x5) and LW (0x6) as: rd=f2, rs=f1, rs read only, write, imm=sign-extended f0.
REQ-013 SHALL decode SW (0x7) as: rs=f1 (base), rt=f2 (data), both reads, no write, imm=sign-extended f0.
REQ-014 SHALL decode BEQ (0x8) as: rs=f2, rt=f1, both reads, no write, imm=sign-extended f0.
REQ-015 SHALL treat NOP (0x0) as no reads and no write, and SHALL issue it normally.
REQ-016 SHALL issue opcodes 0x9-0xF as NOP, with illegal asserted for exactly the one cycle of issue.
REQ-017 SHALL drive addr_rs/addr_rt combinationally from instr, and req_rs/req_rt high only in an issue cycle (in_valid && in_ready) for operands the opcode reads; the register file then captures operands at the same posedge that loads the out_* registers.
REQ-018 SHALL hold a scoreboard of 1<<AWIDTH pending bits, one per register.
REQ-019 SHALL flag a hazard when any register read by instr, or its destination register, is pending after this cycle's release.
REQ-020 SHALL release the pending bit for wb_addr when wb_valid is high, effective the same cycle (write-first-half/read-second-half), so a write landing in the issue cycle does not stall.
REQ-021 SHALL set in_ready = !flush && !hazard && (!out_valid || out_ready).
REQ-022 SHALL, on issue, set the destination's pending bit if it writes and load the out_* registers, with out_valid=1 at the next edge (1-cycle latency).
REQ-023 SHALL, when the same register is set by issue and released by writeback in the same cycle, leave it pending (set wins).
REQ-024 SHALL hold all out_* registers stable while out_valid && !out_ready.
REQ-025 SHALL clear out_valid when out_ready is high and there is no issue.
REQ-026 SHALL, on flush, clear out_valid, clear the pending bit of the held instruction's out_rd if out_wr_en, and accept nothing; wb releases still apply that cycle.
REQ-027 SHALL increment stall_cnt each cycle in_valid && hazard && !flush, saturating at 0xFFFF.

Reset
REQ-028 SHALL, when clear_n is low, asynchronously force out_valid=0, out_op=0, out_rd=0, out_imm=0, out_wr_en=0, illegal=0, stall_cnt=0 and all pending bits to 0.
REQ-029 SHALL, while clear_n is low, hold in_ready=0 and req_rs=req_rt=0.
REQ-030 SHALL leave no residual state from an instruction in flight when reset is asserted mid-operation.
REQ-031 SHALL resume normal operation at the first posedge after clear_n is released.

Verification
REQ-032 Issue: ADD r3,r1,r2 (0x1312), out_ready=1 -> req_rs=req_rt=1 with addr 1/2; next cycle out_valid=1, out_rd=3, out_wr_en=1; pending[3]=1.
REQ-033 RAW stall: ADD r3,.. then SUB r4,r3,r1 (0x2431), no writeback -> in_ready=0 and stall_cnt increments each cycle; wb_valid=1, wb_addr=3 -> SUB issues in that same cycle.
REQ-034 Backpressure and sign extension: out_ready=0 with ADDI r5,r1,-1 (0x551F) held -> in_ready=0 and out_imm=0xFFFF held stable; out_ready=1 -> next instruction accepted.
REQ-035 Flush: LW r6 held in the output stage, flush=1 -> out_valid=0 next cycle, pending[6]=0, and no issue in the flush cycle.
REQ-036 Illegal and set-wins: opcode 0xA -> illegal pulses for 1 cycle with out_wr_en=0; ADD r2 issued while wb_addr=2 -> pending[2] remains 1.
REQ-037 Reset: clear_n=0 mid-stall with pending bits set -> all outputs and pending bits read 0 immediately; after release, a new ADD issues without stall.
